// File: rtl/spi_grid_pkg.sv
// Shared constants and types for the SPI-loaded time-domain accumulate neuron.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default grid geometry, the compute FSM state encoding and the
// depth of the clock-domain-crossing synchronizers used by the core.
package spi_grid_pkg;

  localparam int DATA_W_DEF   = 8;  // register / SPI frame width
  localparam int NUM_REGS_DEF = 3;  // number of grid registers
  localparam int SYNC_STAGES  = 2;  // flops per async input synchronizer

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Mode-0 SPI slave front end: synchronizers, edge detect, rx/tx shifters, bit count.
// Latency: byte_vld_o pulses 1 clk after the synchronized 8th sck rise (3 clk sync+edge before that).
// Backpressure: none; a received byte is presented as a single-cycle strobe and must be taken.
//
// Ports:
//   clk_i, rst_ni          system clock, async active-low reset
//   sck_i, mosi_i, ss_i    raw SPI inputs (asynchronous to clk_i)
//   tx_byte_i              byte loaded into the tx shifter at each ss falling edge
//   miso_o                 SPI data out, MSB first, 0 while not selected
//   byte_vld_o, byte_dat_o one-cycle strobe and the completed received byte
// Macro SPI_GRID_READBACK_EN: when undefined the tx shifter is removed and miso_o is tied to 0.
module spi_slave_if
  import spi_grid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sck_i,
  input  logic              mosi_i,
  input  logic              ss_i,
  input  logic [DATA_W-1:0] tx_byte_i,
  output logic              miso_o,
  output logic              byte_vld_o,
  output logic [DATA_W-1:0] byte_dat_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, mosi_s, ss_s;
  logic                   sck_rise, ss_fall, sel;

  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_shift_q, rx_next;
  logic              byte_vld_q;

  // ss syncs reset to the idle (high) level so reset release never looks like a frame start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign sel      = ~ss_s;
  assign rx_next  = {rx_shift_q[DATA_W-2:0], mosi_s};

  // Holding bit_cnt at 0 while deselected discards any partial frame on ss rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      if (!sel || ss_fall) begin
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        rx_shift_q <= rx_next;
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          bit_cnt_q  <= '0;
          byte_vld_q <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  end

  // rx_shift stays put for several clk after the strobe (sck is much slower than clk).
  assign byte_vld_o = byte_vld_q;
  assign byte_dat_o = rx_shift_q;

`ifdef SPI_GRID_READBACK_EN
  logic              sck_fall;
  logic [DATA_W-1:0] tx_shift_q;
  logic              active_q;

  assign sck_fall = ~sck_s & sck_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_shift_q <= '0;
      active_q   <= 1'b0;
    end else if (!sel) begin
      active_q <= 1'b0;
    end else if (ss_fall) begin
      tx_shift_q <= tx_byte_i;
      active_q   <= 1'b1;
    end else if (sck_fall) begin
      tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
    end
  end

  // Gated by active_q so a stale shifter value never leaks before the load.
  assign miso_o = active_q & tx_shift_q[DATA_W-1];
`else
  logic unused_tx_byte;
  assign unused_tx_byte = ^tx_byte_i;
  assign miso_o         = 1'b0;
`endif

endmodule

// File: rtl/spi_grid_core.sv
// Time-domain accumulate neuron: SPI-loaded weight grid, 2^DATA_W-cycle count-compare accumulate, sign/ReLU.
// Latency: result register valid <= 2^DATA_W + 5 clk after trig rises; grid write <= 3 clk after synced 8th sck rise.
// Backpressure: none; trig and SPI frames arriving while a run is in progress are dropped.
//
// Ports:
//   clk_i, rst_ni       system clock (>= 4x sck), async active-low reset
//   sck_i, mosi_i, ss_i mode-0 SPI slave inputs
//   miso_o              SPI readback of the last result, MSB first
//   trig_i              async start request, rising-edge sensitive
//   sign_i              neuron polarity captured with trig (1 = positive)
// Macro SPI_GRID_READBACK_EN: enables the miso readback path (tied to 0 otherwise).
module spi_grid_core
  import spi_grid_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sck_i,
  input  logic mosi_i,
  input  logic ss_i,
  output logic miso_o,
  input  logic trig_i,
  input  logic sign_i
);

  localparam int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // Sum of NUM_REGS values below 2^DATA_W always fits in DATA_W + PTR_W bits.
  localparam int ACC_W = DATA_W + PTR_W;
  localparam logic [DATA_W-1:0] CNT_MAX = {DATA_W{1'b1}};
  localparam logic [ACC_W-1:0]  SAT     = ACC_W'({DATA_W{1'b1}});

  logic              byte_vld;
  logic [DATA_W-1:0] byte_dat;

  logic [DATA_W-1:0] grid_q [NUM_REGS];
  logic [PTR_W-1:0]  wr_ptr_q;

  logic [SYNC_STAGES-1:0] trig_sync_q, sign_sync_q;
  logic                   trig_prev_q, trig_rise, sign_s;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] out_byte_q, out_byte_d;
  logic [ACC_W-1:0]  hits;

  spi_slave_if #(.DATA_W(DATA_W)) u_spi (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .sck_i      (sck_i),
    .mosi_i     (mosi_i),
    .ss_i       (ss_i),
    .tx_byte_i  (out_byte_q),
    .miso_o     (miso_o),
    .byte_vld_o (byte_vld),
    .byte_dat_o (byte_dat)
  );

  // sign rides the same synchronizer depth as trig so it is captured aligned with the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_sync_q <= '0;
      sign_sync_q <= '0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[SYNC_STAGES-2:0], trig_i};
      sign_sync_q <= {sign_sync_q[SYNC_STAGES-2:0], sign_i};
      trig_prev_q <= trig_sync_q[SYNC_STAGES-1];
    end
  end

  assign trig_rise = trig_sync_q[SYNC_STAGES-1] & ~trig_prev_q;
  assign sign_s    = sign_sync_q[SYNC_STAGES-1];

  // Grid is frozen during RUN so the accumulation sees a stable weight set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) grid_q[i] <= '0;
      wr_ptr_q <= '0;
    end else if (byte_vld && (state_q != RUN)) begin
      grid_q[wr_ptr_q] <= byte_dat;
      wr_ptr_q <= (wr_ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
  end

  // Each cycle every weight still above the ramp contributes one unit;
  // over the full ramp this integrates to the plain sum of the weights.
  always_comb begin
    hits = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (grid_q[i] > cnt_q) hits = hits + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      sign_q     <= 1'b0;
      out_byte_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sign_q     <= sign_d;
      out_byte_q <= out_byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sign_d     = sign_q;
    out_byte_d = out_byte_q;
    case (state_q)
      IDLE: begin
        if (trig_rise) begin
          sign_d  = sign_s;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + hits;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) state_d = DONE;
      end
      DONE: begin
        if (!sign_q)         out_byte_d = '0;
        else if (acc_q > SAT) out_byte_d = CNT_MAX;
        else                 out_byte_d = acc_q[DATA_W-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_grid_core.sv
module tb_spi_grid_core;

  localparam int NREG = 3;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic sck_i  = 1'b0;
  logic mosi_i = 1'b0;
  logic ss_i   = 1'b1;
  logic trig_i = 1'b0;
  logic sign_i = 1'b0;
  logic miso_o;

  always #5 clk_i = ~clk_i;

  spi_grid_core dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sck_i  (sck_i),
    .mosi_i (mosi_i),
    .ss_i   (ss_i),
    .miso_o (miso_o),
    .trig_i (trig_i),
    .sign_i (sign_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: register contents, write pointer, and the result rule.
  logic [7:0] mgrid [NREG];
  int         mptr;

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) mgrid[i] = 8'h00;
    mptr = 0;
  endfunction

  function automatic void model_write(input logic [7:0] b);
    mgrid[mptr] = b;
    mptr = (mptr + 1) % NREG;
  endfunction

  function automatic logic [7:0] model_result(input logic s);
    int sum;
    sum = 0;
    for (int i = 0; i < NREG; i++) sum += int'(mgrid[i]);
    if (!s) return 8'h00;
    return (sum > 255) ? 8'hFF : 8'(sum);
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic spi_open();
    ss_i = 1'b0;
    #80;
  endtask

  task automatic spi_close();
    #80;
    ss_i = 1'b1;
    #80;
  endtask

  // Shift the top n bits of b, MSB first, mode 0.
  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi_i = b[i];
      #40;
      sck_i = 1'b1;
      #40;
      sck_i = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] b);
    spi_open();
    spi_bits(b, 8);
    spi_close();
  endtask

  // Readback uses only 7 sck cycles so it never completes a write frame.
  task automatic spi_read(output logic [7:0] v);
    logic [7:0] rx;
    mosi_i = 1'b0;
    ss_i   = 1'b0;
    #80;
    rx[7] = miso_o;
    for (int i = 6; i >= 0; i--) begin
      sck_i = 1'b1;
      #40;
      sck_i = 1'b0;
      #40;
      rx[i] = miso_o;
    end
    #40;
    ss_i = 1'b1;
    #80;
`ifdef SPI_GRID_READBACK_EN
    v = rx;
`else
    check8("miso_tied_low", rx, 8'h00);
    v = dut.out_byte_q;
`endif
  endtask

  task automatic trig_pulse(input logic s);
    sign_i = s;
    trig_i = 1'b1;
    #50;
    trig_i = 1'b0;
  endtask

  task automatic run_and_wait(input logic s);
    trig_pulse(s);
    clk_wait(300);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic       sgn;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0] rd;
    logic [7:0] b;
    logic       s;
    int         nw;

    tbl[0] = '{b0: 8'h55, b1: 8'h45, b2: 8'h01, sgn: 1'b1, exp: 8'h9B};
    tbl[1] = '{b0: 8'h55, b1: 8'h45, b2: 8'h01, sgn: 1'b0, exp: 8'h00};
    tbl[2] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, sgn: 1'b1, exp: 8'hFF};
    tbl[3] = '{b0: 8'h10, b1: 8'h20, b2: 8'h30, sgn: 1'b1, exp: 8'h60};
    tbl[4] = '{b0: 8'h80, b1: 8'h80, b2: 8'h00, sgn: 1'b1, exp: 8'hFF};
    tbl[5] = '{b0: 8'h00, b1: 8'h00, b2: 8'h01, sgn: 1'b1, exp: 8'h01};

    // Reset state
    clk_wait(5);
    rst_ni = 1'b1;
    clk_wait(5);
    model_clear();
    check8("reset_miso", {7'b0, miso_o}, 8'h00);
    spi_read(rd);
    check8("reset_readback", rd, 8'h00);

    // Table: three bytes in one ss window, then compute and read back
    for (int i = 0; i < 6; i++) begin
      spi_open();
      spi_bits(tbl[i].b0, 8);
      spi_bits(tbl[i].b1, 8);
      spi_bits(tbl[i].b2, 8);
      spi_close();
      model_write(tbl[i].b0);
      model_write(tbl[i].b1);
      model_write(tbl[i].b2);
      run_and_wait(tbl[i].sgn);
      spi_read(rd);
      check8($sformatf("vec%0d", i), rd, tbl[i].exp);
    end

    // Abort after 5 bits, then 4 frames wrapping the pointer
    spi_open();
    spi_bits(8'hE7, 5);
    spi_close();
    spi_frame(8'h01);
    spi_frame(8'h02);
    spi_frame(8'h03);
    spi_frame(8'h10);
    model_write(8'h01);
    model_write(8'h02);
    model_write(8'h03);
    model_write(8'h10);
    check8("idle_miso", {7'b0, miso_o}, 8'h00);
    run_and_wait(1'b1);
    spi_read(rd);
    check8("abort_wrap", rd, 8'h15);

    // Busy: second trig (with opposite sign) and a frame during RUN are dropped
    spi_frame(8'h20);
    spi_frame(8'h30);
    spi_frame(8'h40);
    model_write(8'h20);
    model_write(8'h30);
    model_write(8'h40);
    trig_pulse(1'b1);
    clk_wait(10);
    spi_frame(8'hFF);
    trig_pulse(1'b0);
    clk_wait(300);
    spi_read(rd);
    check8("busy_result", rd, 8'h90);
    spi_frame(8'h00);
    model_write(8'h00);
    run_and_wait(1'b1);
    spi_read(rd);
    check8("busy_ptr_kept", rd, model_result(1'b1));

    // Reset in the middle of a run
    spi_frame(8'h11);
    spi_frame(8'h22);
    spi_frame(8'h33);
    trig_pulse(1'b1);
    clk_wait(100);
    rst_ni = 1'b0;
    clk_wait(2);
    check8("rst_miso", {7'b0, miso_o}, 8'h00);
    rst_ni = 1'b1;
    clk_wait(3);
    model_clear();
    spi_read(rd);
    check8("rst_readback", rd, 8'h00);
    spi_frame(8'h05);
    spi_frame(8'h06);
    spi_frame(8'h07);
    model_write(8'h05);
    model_write(8'h06);
    model_write(8'h07);
    run_and_wait(1'b1);
    spi_read(rd);
    check8("rst_then_run", rd, 8'h12);

    // Randomized writes and polarity against the model
    for (int k = 0; k < 10; k++) begin
      nw = $urandom_range(1, 4);
      for (int j = 0; j < nw; j++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                        : 8'($urandom_range(0, 90));
        spi_frame(b);
        model_write(b);
      end
      s = 1'($urandom_range(0, 3) != 0);
      run_and_wait(s);
      spi_read(rd);
      check8($sformatf("rand%0d", k), rd, model_result(s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
